// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and returns a single-cycle response pulse, aborting completers that stall too long.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // A zero TIMEOUT still needs a legal one-bit counter even though it never aborts.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                rspValid_q, rspValid_d;
  logic [DATA_W-1:0]   rspRdata_q, rspRdata_d;
  logic                rspErr_q, rspErr_d;
  logic                rspTmo_q, rspTmo_d;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      rspTmo_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      rspTmo_q   <= rspTmo_d;
    end
  end

  // Outputs are computed one cycle ahead so every APB and response signal leaves a flop.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    rspValid_d = 1'b0;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    rspTmo_d   = rspTmo_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          waitCnt_d = '0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // Completion is checked before the timeout so a late pready still wins.
        if (pready) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rspValid_d = 1'b1;
          rspErr_d   = pslverr;
          rspTmo_d   = 1'b0;
          rspRdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
          state_d    = IDLE;
        end else if ((TIMEOUT > 0) && (waitCnt_q == CNT_LAST)) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rspValid_d = 1'b1;
          rspErr_d   = 1'b1;
          rspTmo_d   = 1'b1;
          rspRdata_d = '0;
          state_d    = IDLE;
        end else if (waitCnt_q != CNT_MAX) begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign rsp_tmo   = rspTmo_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a scripted APB completer plays back planned
// wait/error behaviour while a monitor checks each response against a transfer-level model.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                waits;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } plan_t;

  typedef struct {
    int                cycle;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              tmo;
  } exp_t;

  plan_t planQ[$];
  exp_t  expQ[$];
  plan_t curPlan;
  int    accessCnt  = 0;
  int    busyUntil  = 0;
  bit    inReset    = 1'b1;
  int    cyc        = 0;
  int    vectors    = 0;
  int    miscompares = 0;

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_tmo  (rsp_tmo),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer-level reference: a completer that stalls for TIMEOUT or more ACCESS cycles is
  // aborted after exactly TIMEOUT of them; otherwise the response lands 3 + waits after accept.
  function automatic exp_t modelResponse(plan_t p, int acceptCycle);
    exp_t e;
    if (TIMEOUT > 0 && p.waits >= TIMEOUT) begin
      e.cycle = acceptCycle + 2 + TIMEOUT;
      e.rdata = '0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
    end else begin
      e.cycle = acceptCycle + 3 + p.waits;
      e.err   = p.err;
      e.tmo   = 1'b0;
      e.rdata = (!p.write && !p.err) ? p.rdata : '0;
    end
    return e;
  endfunction

  // Presents a command with cmd_valid held and returns right after the accepting edge.
  task automatic applyStimulus(input plan_t p);
    int budget;
    exp_t e;
    budget = 0;
    planQ.push_back(p);
    @(negedge pclk);
    cmd_write = p.write;
    cmd_addr  = p.addr;
    cmd_wdata = p.wdata;
    cmd_valid = 1'b1;
    forever begin
      #1;
      if (cmd_ready === 1'b1) begin
        e = modelResponse(p, cyc);
        expQ.push_back(e);
        busyUntil = e.cycle;
        @(posedge pclk);
        return;
      end
      budget++;
      if (budget > 100) begin
        checkOutput("acceptTimeout", 64'(cmd_ready), 64'(1));
        void'(planQ.pop_back());
        return;
      end
      @(negedge pclk);
    end
  endtask

  function automatic plan_t randomPlan();
    plan_t p;
    int r;
    p.write = 1'($urandom);
    p.addr  = $urandom;
    p.wdata = 8'($urandom);
    p.rdata = 8'($urandom);
    p.err   = ($urandom_range(0, 4) == 0);
    r = $urandom_range(0, 19);
    if (r < 10)      p.waits = 0;
    else if (r < 14) p.waits = 1;
    else if (r < 16) p.waits = 2;
    else if (r < 18) p.waits = $urandom_range(3, TIMEOUT - 1);
    else             p.waits = TIMEOUT + $urandom_range(0, 3);
    return p;
  endfunction

  function automatic plan_t mkPlan(logic w, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd,
                                   int waits, logic err, logic [DATA_W-1:0] rd);
    plan_t p;
    p.write = w;
    p.addr  = a;
    p.wdata = wd;
    p.waits = waits;
    p.err   = err;
    p.rdata = rd;
    return p;
  endfunction

  // Scripted completer: answers each ACCESS from the plan of the transfer in flight and
  // drives noise on prdata/pslverr/pready whenever the bridge must ignore them.
  initial begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(negedge pclk);
      if (!inReset && psel === 1'b1 && penable === 1'b0) begin
        if (planQ.size() > 0) curPlan = planQ.pop_front();
        else checkOutput("setupWithoutCommand", 64'(psel), 64'(0));
        accessCnt = 0;
        checkOutput("setupPaddr", 64'(paddr), 64'(curPlan.addr));
        checkOutput("setupPwrite", 64'(pwrite), 64'(curPlan.write));
        checkOutput("setupPwdata", 64'(pwdata), 64'(curPlan.wdata));
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = 8'($urandom);
      end else if (!inReset && psel === 1'b1 && penable === 1'b1) begin
        accessCnt++;
        checkOutput("accessPaddr", 64'(paddr), 64'(curPlan.addr));
        checkOutput("accessPwrite", 64'(pwrite), 64'(curPlan.write));
        checkOutput("accessPwdata", 64'(pwdata), 64'(curPlan.wdata));
        if (accessCnt > curPlan.waits) begin
          pready  = 1'b1;
          pslverr = curPlan.err;
          prdata  = curPlan.rdata;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = 8'($urandom);
        end
      end else begin
        if (!inReset) checkOutput("penableWithoutPsel", 64'(penable), 64'(0));
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = 8'($urandom);
      end
    end
  end

  // Monitor: checks cmd_ready against the model's busy window and scores every response.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!inReset) begin
        checkOutput("cmdReady", 64'(cmd_ready), 64'(cyc >= busyUntil));
        if (rsp_valid === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedRsp", 64'(rsp_valid), 64'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("rspCycle", 64'(cyc), 64'(e.cycle));
            checkOutput("rspRdata", 64'(rsp_rdata), 64'(e.rdata));
            checkOutput("rspErr", 64'(rsp_err), 64'(e.err));
            checkOutput("rspTmo", 64'(rsp_tmo), 64'(e.tmo));
            checkOutput("pselAtRsp", 64'(psel), 64'(0));
          end
        end
      end
    end
  end

  initial begin
    int budget;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge pclk);
    checkOutput("resetPsel", 64'(psel), 64'(0));
    checkOutput("resetPenable", 64'(penable), 64'(0));
    checkOutput("resetRspValid", 64'(rsp_valid), 64'(0));
    checkOutput("resetPaddr", 64'(paddr), 64'(0));
    checkOutput("resetPwdata", 64'(pwdata), 64'(0));
    checkOutput("resetPwrite", 64'(pwrite), 64'(0));
    checkOutput("resetRspFields", 64'({rsp_rdata, rsp_err, rsp_tmo}), 64'(0));
    checkOutput("resetCmdReady", 64'(cmd_ready), 64'(1));
    preset    = 1'b0;
    busyUntil = cyc;
    inReset   = 1'b0;

    applyStimulus(mkPlan(1'b1, 32'h5, 8'hA5, 0, 1'b0, 8'h00));
    applyStimulus(mkPlan(1'b0, 32'h5, 8'h00, 2, 1'b0, 8'hA5));
    applyStimulus(mkPlan(1'b1, 32'h20, 8'h3C, 0, 1'b1, 8'hFF));
    applyStimulus(mkPlan(1'b0, 32'h30, 8'h11, TIMEOUT, 1'b0, 8'h77));
    applyStimulus(mkPlan(1'b0, 32'h31, 8'h22, TIMEOUT - 1, 1'b0, 8'h3C));
    applyStimulus(mkPlan(1'b0, 32'h32, 8'h33, 1, 1'b1, 8'h5A));

    // Reset while the completer is stalling: the transfer must vanish without a response.
    applyStimulus(mkPlan(1'b0, 32'h40, 8'h44, 1000, 1'b0, 8'h99));
    repeat (3) @(negedge pclk);
    cmd_valid = 1'b0;
    preset    = 1'b1;
    #1;
    busyUntil = cyc + 1;
    expQ.delete();
    @(negedge pclk);
    preset = 1'b0;
    checkOutput("midResetPsel", 64'(psel), 64'(0));
    checkOutput("midResetPenable", 64'(penable), 64'(0));
    checkOutput("midResetRspValid", 64'(rsp_valid), 64'(0));

    applyStimulus(mkPlan(1'b1, 32'h7, 8'hC3, 0, 1'b0, 8'h00));
    for (int i = 0; i < 40; i++) applyStimulus(randomPlan());

    @(negedge pclk);
    cmd_valid = 1'b0;
    budget = 0;
    while (expQ.size() > 0 && budget < 200) begin
      @(negedge pclk);
      budget++;
    end
    checkOutput("drainedResponses", 64'(expQ.size()), 64'(0));
    repeat (3) @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
